// File: rtl/serdes_rx_pkg.sv
// Shared definitions for the serial receive path: K28.5 patterns and aligner states.
package serdes_rx_pkg;

  localparam logic [9:0] K28P_10 = 10'h17C;
  localparam logic [9:0] K28N_10 = 10'h283;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_e;

endpackage

// File: rtl/rx_comma_detect.sv
// Combinational comma matcher: flags a window equal to either running-disparity form.
module rx_comma_detect
  import serdes_rx_pkg::*;
#(
  parameter int unsigned      WIDTH = 10,
  parameter logic [WIDTH-1:0] PAT_P = WIDTH'(K28P_10),
  parameter logic [WIDTH-1:0] PAT_N = WIDTH'(K28N_10)
) (
  input  logic [WIDTH-1:0] word,
  output logic             match_c
);

  assign match_c = (word == PAT_P) || (word == PAT_N);

endmodule

// File: rtl/deser_word_align.sv
// Serial-to-parallel receiver that frames WIDTH-bit words and realigns on K28.5 commas,
// tracking lock with HUNT / VERIFY / LOCKED.
module deser_word_align
  import serdes_rx_pkg::*;
#(
  parameter int unsigned      WIDTH    = 10,
  parameter logic [WIDTH-1:0] COMMA_P  = WIDTH'(K28P_10),
  parameter logic [WIDTH-1:0] COMMA_N  = WIDTH'(K28N_10),
  parameter int unsigned      LOCK_CNT = 3,
  parameter int unsigned      LOSS_CNT = 4
) (
  input  logic             BitCLK,
  input  logic             Reset_n,
  input  logic             Serial,
  input  logic             AlignEn,
  output logic [WIDTH-1:0] RxParallel,
  output logic             RxValid,
  output logic             RxComma,
  output logic             Locked,
  output logic             Realign
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned AW = $clog2(LOCK_CNT + 1);
  localparam int unsigned MW = $clog2(LOSS_CNT + 1);

  // The oldest bit drops out of nxt every cycle, so only WIDTH-1 bits are stored.
  logic [WIDTH-1:1] win;
  logic [WIDTH-1:0] nxt;
  logic [CW-1:0]    cnt, cnt_d;
  logic [AW-1:0]    acnt, acnt_d, acnt_inc;
  logic [MW-1:0]    mcnt, mcnt_d, mcnt_inc;
  align_state_e     state, state_d;

  logic             comma, boundary, comma_on, comma_off;
  logic             lock_hit, loss_hit, first_lock, acquire;
  logic [WIDTH-1:0] par_d;
  logic             valid_d, comma_d, realign_d, locked_d;

  assign nxt = {Serial, win};

  rx_comma_detect #(
    .WIDTH (WIDTH),
    .PAT_P (COMMA_P),
    .PAT_N (COMMA_N)
  ) u_comma (
    .word    (nxt),
    .match_c (comma)
  );

  assign boundary  = (cnt == CW'(WIDTH - 1));
  assign comma_on  = comma && boundary;
  assign comma_off = comma && !boundary;

  assign acnt_inc   = (acnt >= AW'(LOCK_CNT)) ? acnt : acnt + AW'(1);
  assign mcnt_inc   = (mcnt >= MW'(LOSS_CNT)) ? mcnt : mcnt + MW'(1);
  assign lock_hit   = (acnt_inc >= AW'(LOCK_CNT));
  assign loss_hit   = (mcnt_inc >= MW'(LOSS_CNT));
  assign first_lock = (LOCK_CNT <= 1);

  // A comma re-anchors framing in HUNT anywhere, in VERIFY only when off the boundary.
  assign acquire = AlignEn && comma &&
                   ((state == HUNT) || ((state == VERIFY) && !boundary));

  always_ff @(posedge BitCLK or negedge Reset_n) begin
    if (!Reset_n) state <= HUNT;
    else          state <= state_d;
  end

  always_comb begin : next_state
    state_d = state;
    if (!AlignEn) begin
      state_d = HUNT;
    end else begin
      case (state)
        HUNT: begin
          if (comma) state_d = first_lock ? LOCKED : VERIFY;
        end
        VERIFY: begin
          if (comma_on && lock_hit)        state_d = LOCKED;
          else if (comma_off && first_lock) state_d = LOCKED;
        end
        LOCKED: begin
          if (comma_off && loss_hit) state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin : out_comb
    cnt_d     = boundary ? '0 : cnt + CW'(1);
    acnt_d    = acnt;
    mcnt_d    = mcnt;
    par_d     = boundary ? nxt : RxParallel;
    valid_d   = 1'b0;
    comma_d   = 1'b0;
    realign_d = 1'b0;
    locked_d  = (state_d == LOCKED);

    if (!AlignEn) begin
      acnt_d  = '0;
      mcnt_d  = '0;
      valid_d = boundary;
      comma_d = comma_on;
    end else begin
      case (state)
        VERIFY: begin
          valid_d = boundary;
          comma_d = comma_on;
          if (comma_on) begin
            acnt_d = acnt_inc;
            if (lock_hit) mcnt_d = '0;
          end
        end
        LOCKED: begin
          valid_d = boundary;
          comma_d = comma_on;
          if (comma_on)       mcnt_d = '0;
          else if (comma_off) mcnt_d = mcnt_inc;
        end
        default: ;
      endcase
    end

    // Forced boundary: emit the comma word and restart the bit counter.
    if (acquire) begin
      par_d     = nxt;
      cnt_d     = '0;
      valid_d   = 1'b1;
      comma_d   = 1'b1;
      realign_d = !boundary;
      acnt_d    = AW'(1);
      mcnt_d    = '0;
    end
  end

  always_ff @(posedge BitCLK or negedge Reset_n) begin
    if (!Reset_n) begin
      win        <= '0;
      cnt        <= '0;
      acnt       <= '0;
      mcnt       <= '0;
      RxParallel <= '0;
      RxValid    <= 1'b0;
      RxComma    <= 1'b0;
      Locked     <= 1'b0;
      Realign    <= 1'b0;
    end else begin
      win        <= nxt[WIDTH-1:1];
      cnt        <= cnt_d;
      acnt       <= acnt_d;
      mcnt       <= mcnt_d;
      RxParallel <= par_d;
      RxValid    <= valid_d;
      RxComma    <= comma_d;
      Locked     <= locked_d;
      Realign    <= realign_d;
    end
  end

endmodule

// File: doc/deser_word_align.md
# deser_word_align

Parametrised serial-to-parallel receiver with comma-based word alignment and lock tracking. It sits after the bit-clock recovery and before the 8b/10b decoder. Each BitCLK cycle it shifts one bit into a WIDTH-bit window, frames WIDTH-bit words, and realigns word boundaries on K28.5 commas. It also reports lock status.

## Interface
- WIDTH, 10: word width in bits; legal range 4..16.
- COMMA_P, 10'h17C: K28.5 RD- pattern. Bit 0 is the first received bit.
- COMMA_N, 10'h283: K28.5 RD+ pattern.
- LOCK_CNT, 3: number of consecutive aligned commas needed to declare lock.
- LOSS_CNT, 4: number of consecutive misaligned commas that drops lock.
- BitCLK  in  1  bit clock; all logic uses the rising edge.
- Reset_n  in  1  reset; asynchronous, active-low.
- Serial  in  1  serial data, sampled every BitCLK.
- AlignEn  in  1  1 = comma alignment enabled; 0 = free-running framing.
- RxParallel  out  WIDTH  last framed word. Bit 0 is the earliest-received bit.
- RxValid  out  1  one-cycle strobe; RxParallel is new this cycle.
- RxComma  out  1  qualifies RxValid; the word equals COMMA_P or COMMA_N.
- Locked  out  1  high while in LOCKED.
- Realign  out  1  one-cycle pulse when the word boundary was moved.

## Operation
- Window update every cycle: nxt = {Serial, win[WIDTH-1:1]}; win <= nxt.
- Comma match is combinational on nxt and compares all WIDTH bits against COMMA_P or COMMA_N.
- Bit counter cnt counts 0..WIDTH-1 and wraps. A boundary occurs when cnt == WIDTH-1.
- At a boundary: RxParallel <= nxt, and RxValid/RxComma are set as gated below.
- AlignEn = 0:
  - State is held in HUNT; Locked = 0.
  - No realignment takes place.
  - RxValid pulses every WIDTH cycles at counter boundaries.
- AlignEn = 1, state machine HUNT / VERIFY / LOCKED:
  - HUNT: RxValid is suppressed.
    - On a comma match in any cycle: force a boundary, so RxParallel <= nxt, cnt <= 0.
    - In the same cycle: pulse Realign, set aligned-comma count acnt = 1, go to VERIFY.
    - That forced word is emitted with RxValid = 1 and RxComma = 1.
  - VERIFY: words are emitted.
    - Comma at a boundary: acnt++. When acnt reaches LOCK_CNT, go to LOCKED and clear the miss count mcnt.
    - Comma off a boundary: realign as in HUNT, set acnt = 1, stay in VERIFY.
  - LOCKED: words are emitted.
    - Comma at a boundary: mcnt = 0.
    - Comma off a boundary: mcnt++, no realignment. When mcnt reaches LOSS_CNT, go to HUNT.
    - The cycle that returns to HUNT does not realign; alignment waits for the next comma.
- Simultaneous events: a comma exactly at a boundary is always treated as aligned and never produces a Realign pulse.
- acnt and mcnt saturate at their limits and are sized $clog2(limit+1).
- AlignEn falling mid-operation: state goes to HUNT next cycle, counters clear, cnt keeps counting.

## Timing
- Reset values: win = 0, cnt = 0, RxParallel = 0, RxValid = 0, RxComma = 0, Locked = 0, Realign = 0, state = HUNT, acnt = mcnt = 0.
- Latency: the last bit of a word is sampled at edge N; RxParallel, RxValid, RxComma and Realign are visible after edge N.
- Locked changes at the same edge as the state register.
- After reset deassertion, the first free-running boundary is at the WIDTHth edge.
- All outputs are registered; there are no combinational paths from input to output.
- Reset asserted mid-word: everything returns to reset values asynchronously, and partial words are discarded.

## Structure
- The shared package serdes_rx_pkg holds:
  - K28P_10 = 10'h17C and K28N_10 = 10'h283.
  - The aligner state enum (HUNT, VERIFY, LOCKED).
- Sub-module rx_comma_detect (parameter WIDTH, patterns): purely combinational match on nxt, reused later by the parallel-mode aligner.
- Top level: window, counter, FSM and output registers, about 180 lines.

## Test plan
- Reset and bypass: Reset_n low, then AlignEn = 0, Serial = 1 → RxValid every 10 cycles, first at edge 10; RxParallel = 10'h3FF; Locked = 0.
- Acquire:
  - Stimulus: AlignEn = 1; K28.5 RD- stream repeated (0x17C per word) with an arbitrary 3-bit offset after reset.
  - Response: Realign once.
  - Response: the first valid word is 0x17C with RxComma = 1.
  - Response: Locked rises on the boundary of the 3rd consecutive aligned comma.
- Data framing while locked: send 0x17C, 0x2A5, 0x15A → RxParallel carries these exact values, each with RxValid, and RxComma only on 0x17C.
- Misaligned comma in VERIFY: after 2 aligned commas, insert one bit slip → Realign pulses, acnt restarts at 1, Locked stays 0 until 3 more aligned commas.
- Loss of lock:
  - Stimulus: in LOCKED, slip by 1 bit and send 4 commas.
  - Response: no Realign; Locked drops after the 4th.
  - Response: the next comma realigns and re-enters VERIFY.
- Reset and AlignEn mid-operation:
  - Reset_n pulsed at cnt = 5 while LOCKED → all outputs 0 immediately; framing restarts.
  - AlignEn dropped while LOCKED → Locked = 0 next cycle.
